// File: rtl/frame_stream_pkg.sv
// Shared types for the frame store-and-forward buffer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package frame_stream_pkg;

  // Widest pointer a descriptor field can carry. Keep DEPTH <= 2**18 so the
  // live pointer width always stays below this.
  localparam int PTR_W_MAX = 20;

  // Input-side receive state.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    DROP     = 2'd2,
    WAIT_LOW = 2'd3
  } in_state_e;

  // One committed frame: first buffer address and beat count (1..DEPTH).
  typedef struct packed {
    logic [PTR_W_MAX-1:0] start_ptr;
    logic [PTR_W_MAX-1:0] length;
  } frame_desc_t;

  // Buffer pointers carry one wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Address width for a power-of-two sized table.
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/frame_stream_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Latency: read data appears the cycle after re; rdata holds when re is low.
// Backpressure: none; the caller only pulses re when the data can be consumed.
module frame_stream_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2048,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: storage array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output register clears on reset so the beat bus idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_stream_fifo.sv
// Store-and-forward frame buffer: drops errored/overflowed/empty frames, replays good ones.
// Latency: first beat of a committed frame is valid 2 cycles after the commit cycle.
// Backpressure: input has none (source-driven); output holds data/last while out_ready is low.
module frame_stream_fifo
  import frame_stream_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAMES = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_frame_valid,
  input  logic              in_data_valid,
  input  logic              in_error,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  drop_err_count,
  output logic [CNT_W-1:0]  drop_ovf_count,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int AW     = idx_w(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int DW     = idx_w(MAX_FRAMES);
  localparam int DPTR_W = DW + 1;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  in_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] start_ptr_q, start_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] frame_start;
  logic [PTR_W-1:0] frame_len;
  logic             err_seen_q, err_seen_d;
  logic             ovf_seen_q, ovf_seen_d;
  logic             buf_full;
  logic             ram_we;
  logic             inc_err, inc_ovf, inc_frame;

  // Descriptor FIFO
  frame_desc_t       desc_mem [MAX_FRAMES];
  frame_desc_t       desc_wdat;
  frame_desc_t       desc_head;
  logic [DPTR_W-1:0] desc_wr_q, desc_rd_q;
  logic              desc_push, desc_pop;
  logic              desc_full, desc_empty;

  // Output side
  logic              out_valid_q, out_last_q;
  logic              active_q;
  logic [PTR_W-1:0]  fetch_ptr_q;
  logic [PTR_W-1:0]  rem_q;
  logic [PTR_W-1:0]  rd_addr;
  logic [PTR_W-1:0]  beats_left;
  logic              can_issue, issue, issue_last, out_accept;
  logic [DATA_W-1:0] ram_rdata;

  // Occupancy uses the registered rd_ptr, so a same-cycle free is not credited yet.
  assign buf_full    = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
  // In IDLE the frame has not latched its start yet; the live write pointer is it.
  assign frame_start = (state_q == IDLE) ? wr_ptr_q : start_ptr_q;
  assign frame_len   = wr_ptr_q - start_ptr_q;

  // Receive state register; a frame in progress during reset is waited out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= in_frame_valid ? WAIT_LOW : IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      err_seen_q  <= 1'b0;
      ovf_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      err_seen_q  <= err_seen_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end

  // Receive next-state: write beats, detect error/overflow, commit or rewind at frame end.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    err_seen_d  = err_seen_q;
    ovf_seen_d  = ovf_seen_q;
    ram_we      = 1'b0;
    desc_push   = 1'b0;
    inc_err     = 1'b0;
    inc_ovf     = 1'b0;
    inc_frame   = 1'b0;

    case (state_q)
      IDLE, RECV: begin
        if (in_frame_valid) begin
          if (state_q == IDLE) begin
            start_ptr_d = wr_ptr_q;
            err_seen_d  = 1'b0;
            ovf_seen_d  = 1'b0;
          end
          state_d = RECV;
          if (in_error) begin
            state_d    = DROP;
            err_seen_d = 1'b1;
            wr_ptr_d   = frame_start;
          end else if (in_data_valid) begin
            if (buf_full) begin
              state_d    = DROP;
              ovf_seen_d = 1'b1;
              wr_ptr_d   = frame_start;
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
          end
        end else if (state_q == RECV) begin
          state_d = IDLE;
          if (frame_len == '0) begin
            // Frame carried no beats: nothing to keep or count.
            wr_ptr_d = wr_ptr_q;
          end else if (desc_full) begin
            wr_ptr_d = start_ptr_q;
            inc_ovf  = 1'b1;
          end else begin
            desc_push = 1'b1;
            inc_frame = 1'b1;
          end
        end
      end
      DROP: begin
        if (!in_frame_valid) begin
          state_d = IDLE;
          if (err_seen_q) begin
            inc_err = 1'b1;
          end else begin
            inc_ovf = 1'b1;
          end
        end else if (in_error) begin
          // A late error still outranks an earlier overflow when counting.
          err_seen_d = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!in_frame_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating drop/commit statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err_count <= '0;
      drop_ovf_count <= '0;
      frame_count    <= '0;
    end else begin
      if (inc_err && drop_err_count != '1) begin
        drop_err_count <= drop_err_count + CNT_W'(1);
      end
      if (inc_ovf && drop_ovf_count != '1) begin
        drop_ovf_count <= drop_ovf_count + CNT_W'(1);
      end
      if (inc_frame && frame_count != '1) begin
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO (pointer pair with wrap bit)
  // ---------------------------------------------------------------------------
  assign desc_empty = (desc_wr_q == desc_rd_q);
  assign desc_full  = (desc_wr_q - desc_rd_q) == DPTR_W'(MAX_FRAMES);
  assign desc_head  = desc_mem[desc_rd_q[DW-1:0]];

  always_comb begin
    desc_wdat           = '0;
    desc_wdat.start_ptr = PTR_W_MAX'(start_ptr_q);
    desc_wdat.length    = PTR_W_MAX'(frame_len);
  end

  // Upper descriptor bits beyond this instance's pointer width are always zero.
  logic unused_desc_hi;
  assign unused_desc_hi = ^{desc_head.start_ptr[PTR_W_MAX-1:PTR_W],
                            desc_head.length[PTR_W_MAX-1:PTR_W]};

  // Descriptor storage write.
  always_ff @(posedge clk) begin
    if (desc_push) begin
      desc_mem[desc_wr_q[DW-1:0]] <= desc_wdat;
    end
  end

  // Descriptor pointers; push and pop in one cycle are both honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_wr_q <= '0;
      desc_rd_q <= '0;
    end else begin
      if (desc_push) begin
        desc_wr_q <= desc_wr_q + DPTR_W'(1);
      end
      if (desc_pop) begin
        desc_rd_q <= desc_rd_q + DPTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output side: the RAM read register is the output data stage.
  // A read is only issued when the output stage is empty or being drained,
  // so the RAM register naturally holds the beat during a stall.
  // ---------------------------------------------------------------------------
  assign out_accept = out_valid_q && out_ready;
  assign can_issue  = !out_valid_q || out_ready;
  assign issue      = can_issue && (active_q || !desc_empty);
  assign rd_addr    = active_q ? fetch_ptr_q : desc_head.start_ptr[PTR_W-1:0];
  assign beats_left = active_q ? rem_q : desc_head.length[PTR_W-1:0];
  assign issue_last = (beats_left == PTR_W'(1));
  // The descriptor slot frees once its final beat has been fetched.
  assign desc_pop   = issue && issue_last;

  // Fetch sequencing, output valid/last and the consumer-side read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      active_q    <= 1'b0;
      fetch_ptr_q <= '0;
      rem_q       <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (out_accept) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (issue) begin
        out_valid_q <= 1'b1;
        out_last_q  <= issue_last;
        fetch_ptr_q <= rd_addr + PTR_W'(1);
        rem_q       <= beats_left - PTR_W'(1);
        active_q    <= !issue_last;
      end else if (out_accept) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  frame_stream_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .re    (issue),
    .raddr (rd_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = ram_rdata;

endmodule

// File: tb/tb_frame_stream_fifo.sv
// Directed bench for frame_stream_fifo (DEPTH=64, MAX_FRAMES=2).
// Latency: checks first beat at commit+2 and full-frame replay order.
// Backpressure: exercises stalls, held data and patterned out_ready.
module tb_frame_stream_fifo;

  logic        clk;
  logic        rst;
  logic        in_frame_valid;
  logic        in_data_valid;
  logic        in_error;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] drop_err_count;
  logic [15:0] drop_ovf_count;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit pat_on = 1'b0;
  logic [15:0] pat = 16'b1011_0010_1101_0110;

  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [7:0] exp_data [$];
  logic       exp_last [$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;

  frame_stream_fifo #(
    .DATA_W     (8),
    .DEPTH      (64),
    .MAX_FRAMES (2),
    .CNT_W      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_frame_valid (in_frame_valid),
    .in_data_valid  (in_data_valid),
    .in_error       (in_error),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .drop_err_count (drop_err_count),
    .drop_ovf_count (drop_ovf_count),
    .frame_count    (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pat_on) out_ready = pat[cyc % 16];
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_frame(input int len, input int base, input int err_at);
    for (int i = 0; i < len; i++) begin
      step();
      in_frame_valid = 1'b1;
      in_data_valid  = 1'b1;
      in_data        = 8'(base + i);
      in_error       = (i == err_at);
    end
    step();
    in_frame_valid = 1'b0;
    in_data_valid  = 1'b0;
    in_error       = 1'b0;
    in_data        = '0;
  endtask

  task automatic expect_frame(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      exp_data.push_back(8'(base + i));
      exp_last.push_back(i == len - 1);
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_beats"}, got_data.size(), exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s_last[%0d]", tag, i), got_last[i], exp_last[i]);
    end
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  task automatic check_counts(input string tag, input int f, input int e, input int o);
    @(negedge clk);
    check({tag, "_frame_count"}, frame_count, f);
    check({tag, "_drop_err"}, drop_err_count, e);
    check({tag, "_drop_ovf"}, drop_ovf_count, o);
  endtask

  // Collect accepted beats and verify held data across stall cycles.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    rst            = 1'b1;
    in_frame_valid = 1'b0;
    in_data_valid  = 1'b0;
    in_error       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b1;

    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check_counts("rst", 0, 0, 0);
    step();
    rst = 1'b0;

    // 1: 64-beat frame, first beat at commit+2
    send_frame(64, 8'h00, -1);
    expect_frame(64, 8'h00);
    @(negedge clk);
    check("t1_valid_n0", out_valid, 1'b0);
    step();
    @(negedge clk);
    check("t1_valid_n1", out_valid, 1'b0);
    step();
    @(negedge clk);
    check("t1_valid_n2", out_valid, 1'b1);
    check("t1_first_data", out_data, 8'h00);
    check("t1_first_last", out_last, 1'b0);
    idle(70);
    compare_stream("t1");
    check_counts("t1", 1, 0, 0);

    // 2: errored frame dropped, following good frame reuses the space
    send_frame(10, 8'h80, 5);
    idle(2);
    send_frame(4, 8'hA0, -1);
    expect_frame(4, 8'hA0);
    idle(15);
    compare_stream("t2");
    check_counts("t2", 2, 1, 0);

    // 3: oversize frame overflows; exactly-full frame then commits
    out_ready = 1'b0;
    send_frame(70, 8'h10, -1);
    idle(2);
    check_counts("t3_ovf", 2, 1, 1);
    check("t3_no_output", out_valid, 1'b0);
    send_frame(64, 8'h40, -1);
    expect_frame(64, 8'h40);
    idle(4);
    @(negedge clk);
    check("t3_stall_valid", out_valid, 1'b1);
    check("t3_stall_data", out_data, 8'h40);
    check_counts("t3_commit", 3, 1, 1);
    step();
    out_ready = 1'b1;
    idle(70);
    compare_stream("t3");

    // 4: descriptor table full, third frame dropped
    out_ready = 1'b0;
    send_frame(3, 8'h01, -1);
    idle(2);
    send_frame(3, 8'h11, -1);
    idle(2);
    send_frame(3, 8'h21, -1);
    idle(3);
    @(negedge clk);
    check("t4_stall_valid", out_valid, 1'b1);
    check("t4_stall_data", out_data, 8'h01);
    check_counts("t4_drop", 5, 1, 2);
    step();
    out_ready = 1'b1;
    expect_frame(3, 8'h01);
    expect_frame(3, 8'h11);
    idle(12);
    compare_stream("t4");

    // 5: patterned backpressure, plus an empty frame pulse
    pat_on = 1'b1;
    send_frame(5, 8'h50, -1);
    expect_frame(5, 8'h50);
    idle(25);
    step();
    in_frame_valid = 1'b1;
    step();
    in_frame_valid = 1'b0;
    idle(10);
    check_counts("t5_empty", 6, 1, 2);
    send_frame(7, 8'h60, -1);
    expect_frame(7, 8'h60);
    idle(25);
    send_frame(4, 8'h70, -1);
    expect_frame(4, 8'h70);
    idle(30);
    pat_on    = 1'b0;
    out_ready = 1'b1;
    idle(5);
    compare_stream("t5");
    check_counts("t5", 8, 1, 2);

    // 6: reset in the middle of a frame that keeps going afterwards
    for (int i = 0; i < 3; i++) begin
      step();
      in_frame_valid = 1'b1;
      in_data_valid  = 1'b1;
      in_data        = 8'(8'h90 + i);
    end
    step();
    rst     = 1'b1;
    in_data = 8'h93;
    step();
    in_data = 8'h94;
    @(negedge clk);
    check("t6_rst_valid", out_valid, 1'b0);
    check_counts("t6_rst", 0, 0, 0);
    step();
    rst     = 1'b0;
    in_data = 8'h95;
    for (int i = 6; i < 8; i++) begin
      step();
      in_data = 8'(8'h90 + i);
    end
    step();
    in_frame_valid = 1'b0;
    in_data_valid  = 1'b0;
    in_data        = '0;
    idle(6);
    compare_stream("t6_trunc");
    check_counts("t6_before", 0, 0, 0);
    send_frame(3, 8'hC0, -1);
    expect_frame(3, 8'hC0);
    idle(8);
    compare_stream("t6");
    check_counts("t6", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_stream_fifo.md
Name: frame_stream_fifo

Overview:
Parametrised store-and-forward buffer for the frame stream. Accepts the source-driven, no-backpressure frame stream (frame_valid/data_valid/error/data) with DATA_W-wide data. Buffers each frame whole, discards errored, overflowed or empty frames, and replays good frames on a ready/valid/last output that supports backpressure. It sits between a MAC receive path and any consumer that may stall.

Parameters:
DATA_W, 8, width of in_data/out_data
DEPTH, 2048, data buffer entries (power of 2, >= 4); also the maximum frame length in beats
MAX_FRAMES, 16, committed-frame descriptor slots (power of 2, >= 2)
CNT_W, 16, width of the saturating drop counters

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
in_frame_valid  in  1  high for the duration of one input frame
in_data_valid  in  1  in_data valid this cycle
in_error  in  1  current input frame is bad
in_data  in  DATA_W  input beat
out_valid  out  1  out_data/out_last valid
out_ready  in  1  consumer accepts the beat when out_valid && out_ready
out_data  out  DATA_W  output beat
out_last  out  1  final beat of the frame
drop_err_count  out  CNT_W  frames dropped for in_error, saturating
drop_ovf_count  out  CNT_W  frames dropped for buffer/descriptor overflow, saturating
frame_count  out  CNT_W  frames committed, saturating

Behaviour:
- Reset: all pointers, counters and state cleared. out_valid=0, out_last=0, out_data=0, all counts=0. Reset wins over every other event.
- Input FSM states are IDLE, RECV, DROP and WAIT_LOW.
- After reset the FSM enters WAIT_LOW if in_frame_valid=1, otherwise IDLE. WAIT_LOW returns to IDLE on in_frame_valid=0. A frame truncated by reset is not counted.
- IDLE -> RECV on in_frame_valid=1. A data beat in that same cycle is accepted.
- RECV: each in_data_valid beat is written at wr_ptr and wr_ptr increments. start_ptr holds the frame's first address.
- RECV -> DROP when either of these occurs:
  - in_error=1: reason ERR.
  - a beat arrives with the buffer full (wr_ptr - rd_ptr == DEPTH): reason OVF. The full-cycle beat is not written.
- DROP: wr_ptr is rewound to start_ptr. All beats are ignored until in_frame_valid=0.
- Leaving DROP increments drop_err_count or drop_ovf_count (ERR has priority if both occurred), then -> IDLE.
- RECV with in_frame_valid=0 (frame end, cycle N):
  - Beat count 0: discarded silently, no counter change.
  - Descriptor FIFO full: rewind, drop_ovf_count++.
  - Otherwise: push descriptor {start_ptr, length} and frame_count++.
  - In every case -> IDLE.
- in_error or in_data_valid while in_frame_valid=0 is ignored.
- Pointers are clog2(DEPTH)+1 bits and wrap naturally. Length field is clog2(DEPTH)+1 bits, and length is in 1..DEPTH.
- Output:
  - The first beat of a committed frame presents out_valid=1 exactly 2 cycles after the commit cycle N, provided the output was idle.
  - out_data/out_last are held stable while out_valid && !out_ready.
  - Back-to-back frames stream with no idle cycle when out_ready stays high.
  - out_last=1 only on the descriptor's final beat.
  - Each accepted beat advances rd_ptr, freeing space immediately.
- A commit and an output read in the same cycle are both honoured. A write and a free in the same cycle use the pre-update rd_ptr for the full check (conservative).
- Counters saturate at all-ones.
- Throughput: 1 beat/cycle in, 1 beat/cycle out.

Decomposition:
- Package frame_stream_pkg holds:
  - typedef frame_desc_t {start_ptr, length}
  - enum in_state_e {IDLE, RECV, DROP, WAIT_LOW}
  - localparam helpers for pointer and length widths
- Sub-module frame_stream_ram: simple dual-port RAM, one write port and one registered read port, DEPTH x DATA_W.
- The descriptor FIFO is small and lives inline.

Test Plan:
1. 64-beat frame 0x00..0x3F, out_ready=1 -> out_valid rises at N+2; 64 beats in order; out_last on 0x3F; frame_count=1.
2. 10-beat frame with in_error pulsed on beat 5, followed by a good 4-beat frame -> only the 4 beats appear; drop_err_count=1; wr_ptr rewound (buffer reuse verified).
3. DEPTH=16, out_ready=0, 20-beat frame -> dropped; drop_ovf_count=1; a following 16-beat frame commits and is replayed in full.
4. MAX_FRAMES=2, out_ready=0, three 3-beat frames -> third dropped with drop_ovf_count=1; on releasing out_ready, 6 beats with out_last on beats 3 and 6.
5. out_ready toggled randomly across 3 frames -> data held stable while stalled; no loss or duplication; a frame_valid pulse with zero beats produces no output and no count change.
6. rst asserted mid-frame while in_frame_valid stays high -> outputs cleared; remainder ignored until in_frame_valid=0; the next frame is passed correctly with all counts=0 beforehand.
